// File: rtl/vote_arbiter_ctrl.sv
// Debounced single-press vote arbiter. Presses are debounced, committed once,
// then the block locks out and waits for release.
module vote_arbiter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic [3:0] btn,
  output logic       busy,
  output logic       valid_vote_casted,
  output logic [3:0] cand_inc,
  output logic       vote_error,
  output logic [7:0] candidate1_vote,
  output logic [7:0] candidate2_vote,
  output logic [7:0] candidate3_vote,
  output logic [7:0] candidate4_vote
);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_DEBOUNCE     = 3'd1,
    ST_COMMIT       = 3'd2,
    ST_LOCKOUT      = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } state_t;

  localparam logic [7:0]  DEB_LOAD  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_CYCLES - 1);

  state_t      state_r;
  state_t      state_s;
  logic        err_s;
  logic [3:0]  sel_r;
  logic [7:0]  deb_cnt_r;
  logic [15:0] lock_cnt_r;
  logic        vote_error_r;
  logic [7:0]  votes_r [4];

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and conflict detection
  always_comb begin
    state_s = state_r;
    err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mode) begin
          state_s = ST_IDLE;
        end else if (popcount4(btn) == 3'd1) begin
          state_s = ST_DEBOUNCE;
        end else if (popcount4(btn) >= 3'd2) begin
          err_s   = 1'b1;
          state_s = ST_WAIT_RELEASE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        if (mode) begin
          state_s = ST_IDLE;
        end else if ((btn & ~sel_r) != 4'b0000) begin
          err_s   = 1'b1;
          state_s = ST_WAIT_RELEASE;
        end else if (btn == sel_r) begin
          state_s = (deb_cnt_r == 8'd0) ? ST_COMMIT : ST_DEBOUNCE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        state_s = ST_LOCKOUT;
      end
      ST_LOCKOUT: begin
        state_s = (lock_cnt_r == 16'd0) ? ST_WAIT_RELEASE : ST_LOCKOUT;
      end
      ST_WAIT_RELEASE: begin
        if (mode || (btn == 4'b0000)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_RELEASE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy              = (state_r != ST_IDLE);
    valid_vote_casted = (state_r == ST_COMMIT);
    cand_inc          = (state_r == ST_COMMIT) ? sel_r : 4'b0000;
    vote_error        = vote_error_r;
  end

  // Latched button, counters, error pulse and saturating totals
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_r        <= 4'b0000;
      deb_cnt_r    <= 8'd0;
      lock_cnt_r   <= 16'd0;
      vote_error_r <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        votes_r[i] <= 8'd0;
      end
    end else begin
      vote_error_r <= err_s;
      if ((state_r == ST_IDLE) && (state_s == ST_DEBOUNCE)) begin
        sel_r     <= btn;
        deb_cnt_r <= DEB_LOAD;
      end else if ((state_r == ST_DEBOUNCE) && (state_s == ST_DEBOUNCE)) begin
        deb_cnt_r <= deb_cnt_r - 8'd1;
      end else begin
        deb_cnt_r <= deb_cnt_r;
      end
      if (state_r == ST_COMMIT) begin
        lock_cnt_r <= LOCK_LOAD;
        for (int i = 0; i < 4; i++) begin
          // Saturate rather than wrap; the pulse still goes out at 255
          if (sel_r[i] && (votes_r[i] != 8'd255)) begin
            votes_r[i] <= votes_r[i] + 8'd1;
          end
        end
      end else if ((state_r == ST_LOCKOUT) && (lock_cnt_r != 16'd0)) begin
        lock_cnt_r <= lock_cnt_r - 16'd1;
      end else begin
        lock_cnt_r <= lock_cnt_r;
      end
    end
  end

  assign candidate1_vote = votes_r[0];
  assign candidate2_vote = votes_r[1];
  assign candidate3_vote = votes_r[2];
  assign candidate4_vote = votes_r[3];

endmodule

// File: doc/vote_arbiter_ctrl.md
VOTE_ARBITER_CTRL -- requirements
Module: vote_arbiter_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable sampled cycles required before a press is accepted (legal range 1..255).
REQ-002 Parameter LOCKOUT_CYCLES, default 16, meaning post-vote dead time in cycles during which all buttons are ignored (legal range 1..65535).
REQ-003 Port reset is synchronous and active-high; the clock is `clock`, rising edge; all state is updated only on that edge.
REQ-004 Port list, one per line (name, direction, width, meaning):
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- mode  in  1  0 = voting, 1 = result (voting blocked)
- btn  in  4  candidate buttons, bit i = candidate i+1, already synchronised
- busy  out  1  high whenever state is not IDLE
- valid_vote_casted  out  1  one-cycle pulse per accepted vote
- cand_inc  out  4  one-hot pulse coincident with valid_vote_casted
- vote_error  out  1  one-cycle pulse on a multi-button conflict
- candidate1_vote..candidate4_vote  out  8 each  per-candidate vote totals
REQ-005 All outputs shall be registered or decoded from registered state only, with no combinational path from any input to any output.

Function
REQ-006 The FSM shall have exactly five states: IDLE, DEBOUNCE, COMMIT, LOCKOUT, WAIT_RELEASE.
REQ-007 In IDLE with mode=0 and exactly one btn bit high, the next state shall be DEBOUNCE, the button index shall be latched, and the debounce counter shall be loaded with DEBOUNCE_CYCLES-1.
REQ-008 In IDLE with mode=0 and two or more btn bits high, vote_error shall pulse for one cycle and the next state shall be WAIT_RELEASE.
REQ-009 In DEBOUNCE, each cycle in which btn equals the latched one-hot value shall decrement the counter; when the counter is 0 with btn still matching, the next state shall be COMMIT.
REQ-010 In DEBOUNCE, if the latched bit drops while no other bit is high, the next state shall be IDLE with no vote and no error.
REQ-011 In DEBOUNCE, if any other bit rises, vote_error shall pulse and the next state shall be WAIT_RELEASE with no vote.
REQ-012 COMMIT shall last exactly one cycle, during which valid_vote_casted=1 and cand_inc equals the latched one-hot value; the next state shall be LOCKOUT.
REQ-013 Latency for DEBOUNCE_CYCLES=D: with btn sampled high at edges 0..D, valid_vote_casted shall be high from edge D to edge D+1, and the selected candidateN_vote shall update at edge D+1.
REQ-014 Vote totals shall increment by 1 per commit and saturate at 255 with no wrap; at saturation the valid_vote_casted and cand_inc pulses shall still be issued.
REQ-015 LOCKOUT shall hold for LOCKOUT_CYCLES cycles, ignoring btn and mode, then go to WAIT_RELEASE.
REQ-016 WAIT_RELEASE shall go to IDLE on the first edge at which btn=4'b0000.
REQ-017 mode=1 sampled in IDLE, DEBOUNCE or WAIT_RELEASE shall force the next state to IDLE with no vote and no error; a COMMIT already entered shall complete.
REQ-018 In mode=1, IDLE shall accept no presses; vote totals shall hold and remain readable.
REQ-019 At most one commit shall occur per press, including when a button is held indefinitely.

Reset
REQ-020 Reset shall take priority over all other inputs, including mid-DEBOUNCE, COMMIT and LOCKOUT.
REQ-021 On reset, the FSM shall go to IDLE and busy, valid_vote_casted, cand_inc and vote_error shall be 0.
REQ-022 On reset, all four vote totals shall be 0 and the debounce and lockout counters shall be 0.
REQ-023 No vote shall be counted for a press in progress at reset; a button still held after reset deasserts is treated as a fresh press from IDLE.

Verification
REQ-024 Scenario: mode=0, btn=0001 held for 5 edges then released -> one valid_vote_casted pulse, cand_inc=0001, candidate1_vote=1, then back in IDLE after 16 lockout cycles plus one release cycle.
REQ-025 Scenario: btn=0100 held 3 edges then dropped -> no pulse, candidate3_vote=0, busy low again.
REQ-026 Scenario: btn=0011 applied in IDLE -> vote_error one-cycle pulse, no vote; a release then btn=0010 for 5 edges -> candidate2_vote=1.
REQ-027 Scenario: 260 clean presses of btn=1000 -> candidate4_vote=255, 260 valid pulses.
REQ-028 Scenario: reset asserted in the COMMIT cycle, and separately mid-LOCKOUT -> all totals 0 and the FSM in IDLE on the next cycle.
REQ-029 Scenario: mode=1 while btn=0001 is held for 20 cycles -> no pulse and totals unchanged; mode returned to 0 with btn still held -> a vote is accepted D+1 edges later.
